// File: rtl/cpu_fetch_hazard.sv
// cpu_fetch_hazard: MIPS fetch stage owning the PC and the IF/ID register, with
// load-use stall, branch/jump redirect and EX-stage forwarding selects.
// Optional macro HAZARD_STATS_EN adds saturating stall/redirect counters.
module cpu_fetch_hazard #(
    parameter int unsigned PC_W     = 8,
    parameter int unsigned INST_W   = 32,
    parameter int unsigned PC_STEP  = 4,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk_CPU,
    input  logic              rst_CPU_n,
    input  logic [INST_W-1:0] instr_IN,
    output logic [PC_W-1:0]   pc_OUT,
    output logic [INST_W-1:0] id_instr_OUT,
    output logic [PC_W-1:0]   id_nextInst_OUT,
    output logic              id_valid_OUT,
    input  logic              id_jump_IN,
    input  logic [PC_W-1:0]   id_jumpTarget_IN,
    input  logic              mem_branchTaken_IN,
    input  logic [PC_W-1:0]   mem_branchTarget_IN,
    input  logic              ex_memRead_IN,
    input  logic [4:0]        ex_rs_IN,
    input  logic [4:0]        ex_rt_IN,
    input  logic              mem_regWrite_IN,
    input  logic              wb_regWrite_IN,
    input  logic [4:0]        mem_rd_IN,
    input  logic [4:0]        wb_rd_IN,
`ifdef HAZARD_STATS_EN
    output logic [15:0]       stallCount_OUT,
    output logic [15:0]       flushCount_OUT,
`endif
    output logic              stall_OUT,
    output logic              flush_OUT,
    output logic [1:0]        fwdA_OUT,
    output logic [1:0]        fwdB_OUT
);

    localparam logic [PC_W-1:0] PcStep  = PC_W'(PC_STEP);
    localparam logic [PC_W-1:0] PcReset = PC_W'(RESET_PC);

    logic [PC_W-1:0]   pc_reg, pc_next;
    logic [INST_W-1:0] instr_reg, instr_next;
    logic [PC_W-1:0]   next_inst_reg, next_inst_next;
    logic              valid_reg, valid_next;

    logic [PC_W-1:0] pc_plus;
    logic [5:0]      id_op;
    logic [4:0]      id_rs, id_rt;
    logic            id_reads_rt;
    logic            load_use;
    logic            jump_go;

    assign pc_plus = pc_reg + PcStep;
    assign id_op   = instr_reg[31:26];
    assign id_rs   = instr_reg[25:21];
    assign id_rt   = instr_reg[20:16];

    // R-type, sw, beq and bne read rt as a source; other opcodes write it.
    assign id_reads_rt = (id_op == 6'h00) || (id_op == 6'h2B) ||
                         (id_op == 6'h04) || (id_op == 6'h05);

    assign load_use = valid_reg && ex_memRead_IN && (ex_rt_IN != 5'd0) &&
                      ((ex_rt_IN == id_rs) || ((ex_rt_IN == id_rt) && id_reads_rt));

    assign jump_go   = id_jump_IN && valid_reg;
    assign flush_OUT = mem_branchTaken_IN;
    // A redirect kills the instruction in ID, so a stall on it is meaningless.
    assign stall_OUT = load_use && !mem_branchTaken_IN && !jump_go;

    function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic mem_we,
                                           input logic [4:0] mem_rd, input logic wb_we,
                                           input logic [4:0] wb_rd);
        if (mem_we && (mem_rd != 5'd0) && (mem_rd == src)) begin
            return 2'b10;
        end else if (wb_we && (wb_rd != 5'd0) && (wb_rd == src)) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    assign fwdA_OUT = fwd_sel(ex_rs_IN, mem_regWrite_IN, mem_rd_IN, wb_regWrite_IN, wb_rd_IN);
    assign fwdB_OUT = fwd_sel(ex_rt_IN, mem_regWrite_IN, mem_rd_IN, wb_regWrite_IN, wb_rd_IN);

    // Next PC and IF/ID contents, branch beats jump beats stall beats fetch.
    always_comb begin
        pc_next        = pc_plus;
        instr_next     = instr_IN;
        next_inst_next = pc_plus;
        valid_next     = 1'b1;
        if (mem_branchTaken_IN) begin
            pc_next        = mem_branchTarget_IN;
            instr_next     = '0;
            next_inst_next = '0;
            valid_next     = 1'b0;
        end else if (jump_go) begin
            pc_next        = id_jumpTarget_IN;
            instr_next     = '0;
            next_inst_next = '0;
            valid_next     = 1'b0;
        end else if (load_use) begin
            pc_next        = pc_reg;
            instr_next     = instr_reg;
            next_inst_next = next_inst_reg;
            valid_next     = valid_reg;
        end
    end

    // PC and IF/ID registers.
    always_ff @(posedge clk_CPU or negedge rst_CPU_n) begin
        if (!rst_CPU_n) begin
            pc_reg        <= PcReset;
            instr_reg     <= '0;
            next_inst_reg <= '0;
            valid_reg     <= 1'b0;
        end else begin
            pc_reg        <= pc_next;
            instr_reg     <= instr_next;
            next_inst_reg <= next_inst_next;
            valid_reg     <= valid_next;
        end
    end

    assign pc_OUT          = pc_reg;
    assign id_instr_OUT    = instr_reg;
    assign id_nextInst_OUT = next_inst_reg;
    assign id_valid_OUT    = valid_reg;

`ifdef HAZARD_STATS_EN
    logic [15:0] stall_count_reg, flush_count_reg;

    // Saturating event counters for stall cycles and redirects.
    always_ff @(posedge clk_CPU or negedge rst_CPU_n) begin
        if (!rst_CPU_n) begin
            stall_count_reg <= '0;
            flush_count_reg <= '0;
        end else begin
            if (stall_OUT && (stall_count_reg != 16'hFFFF)) begin
                stall_count_reg <= stall_count_reg + 16'd1;
            end
            if ((mem_branchTaken_IN || jump_go) && (flush_count_reg != 16'hFFFF)) begin
                flush_count_reg <= flush_count_reg + 16'd1;
            end
        end
    end

    assign stallCount_OUT = stall_count_reg;
    assign flushCount_OUT = flush_count_reg;
`endif

endmodule

// File: tb/tb_cpu_fetch_hazard.sv
// Randomized scoreboard bench for cpu_fetch_hazard against a cycle-level reference model.
module tb_cpu_fetch_hazard;

    localparam int unsigned PC_W     = 8;
    localparam int unsigned INST_W   = 32;
    localparam int unsigned PC_STEP  = 4;
    localparam int unsigned RESET_PC = 0;

    logic              clk_CPU = 1'b0;
    logic              rst_CPU_n = 1'b0;
    logic [INST_W-1:0] instr_IN;
    logic [PC_W-1:0]   pc_OUT;
    logic [INST_W-1:0] id_instr_OUT;
    logic [PC_W-1:0]   id_nextInst_OUT;
    logic              id_valid_OUT;
    logic              id_jump_IN;
    logic [PC_W-1:0]   id_jumpTarget_IN;
    logic              mem_branchTaken_IN;
    logic [PC_W-1:0]   mem_branchTarget_IN;
    logic              ex_memRead_IN;
    logic [4:0]        ex_rs_IN, ex_rt_IN;
    logic              mem_regWrite_IN, wb_regWrite_IN;
    logic [4:0]        mem_rd_IN, wb_rd_IN;
    logic              stall_OUT, flush_OUT;
    logic [1:0]        fwdA_OUT, fwdB_OUT;
`ifdef HAZARD_STATS_EN
    logic [15:0]       stallCount_OUT, flushCount_OUT;
`endif

    logic [31:0] imem [64];
    assign instr_IN = imem[pc_OUT[7:2]];

    cpu_fetch_hazard #(
        .PC_W(PC_W), .INST_W(INST_W), .PC_STEP(PC_STEP), .RESET_PC(RESET_PC)
    ) dut (
        .clk_CPU(clk_CPU), .rst_CPU_n(rst_CPU_n), .instr_IN(instr_IN),
        .pc_OUT(pc_OUT), .id_instr_OUT(id_instr_OUT), .id_nextInst_OUT(id_nextInst_OUT),
        .id_valid_OUT(id_valid_OUT), .id_jump_IN(id_jump_IN),
        .id_jumpTarget_IN(id_jumpTarget_IN), .mem_branchTaken_IN(mem_branchTaken_IN),
        .mem_branchTarget_IN(mem_branchTarget_IN), .ex_memRead_IN(ex_memRead_IN),
        .ex_rs_IN(ex_rs_IN), .ex_rt_IN(ex_rt_IN), .mem_regWrite_IN(mem_regWrite_IN),
        .wb_regWrite_IN(wb_regWrite_IN), .mem_rd_IN(mem_rd_IN), .wb_rd_IN(wb_rd_IN),
`ifdef HAZARD_STATS_EN
        .stallCount_OUT(stallCount_OUT), .flushCount_OUT(flushCount_OUT),
`endif
        .stall_OUT(stall_OUT), .flush_OUT(flush_OUT),
        .fwdA_OUT(fwdA_OUT), .fwdB_OUT(fwdB_OUT)
    );

    always #5 clk_CPU = ~clk_CPU;

    typedef struct {
        int unsigned pc;
        int unsigned instr;
        int unsigned nxt;
        int unsigned valid;
        int unsigned stall;
        int unsigned flush;
        int unsigned fa;
        int unsigned fb;
        int unsigned sc;
        int unsigned fc;
    } exp_t;

    exp_t q[$];
    int tests = 0;
    int fails = 0;

    // Reference model state
    int unsigned m_pc, m_instr, m_next, m_valid, m_sc, m_fc;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned fwd_model(int unsigned src, bit mw, int unsigned md,
                                              bit ww, int unsigned wd);
        if (mw && md != 0 && md == src) return 2;
        if (ww && wd != 0 && wd == src) return 1;
        return 0;
    endfunction

    function automatic logic [7:0] pick_target();
        int unsigned k = $urandom_range(0, 3);
        if (k == 0) return 8'hFC;
        if (k == 1) return 8'hF8;
        return 8'($urandom_range(0, 63) * 4);
    endfunction

    task automatic model_reset();
        m_pc = RESET_PC; m_instr = 0; m_next = 0; m_valid = 0; m_sc = 0; m_fc = 0;
    endtask

    // Drive one cycle of random inputs, queue the expected outputs, advance the model.
    task automatic drive_and_predict(output bit stall_e);
        exp_t e;
        int unsigned op, rs, rt;
        bit reads_rt, hazard, br, jump_go;
        mem_branchTaken_IN  = ($urandom_range(0, 7) == 0);
        mem_branchTarget_IN = pick_target();
        id_jump_IN          = ($urandom_range(0, 5) == 0);
        id_jumpTarget_IN    = pick_target();
        ex_memRead_IN       = 1'($urandom_range(0, 1));
        ex_rs_IN            = 5'($urandom_range(0, 3));
        ex_rt_IN            = 5'($urandom_range(0, 3));
        mem_regWrite_IN     = 1'($urandom_range(0, 1));
        wb_regWrite_IN      = 1'($urandom_range(0, 1));
        mem_rd_IN           = 5'($urandom_range(0, 3));
        wb_rd_IN            = 5'($urandom_range(0, 3));

        op = m_instr >> 26;
        rs = (m_instr >> 21) % 32;
        rt = (m_instr >> 16) % 32;
        reads_rt = (op == 0) || (op == 'h2B) || (op == 4) || (op == 5);
        hazard = (m_valid == 1) && ex_memRead_IN && ex_rt_IN != 0 &&
                 (ex_rt_IN == rs || (ex_rt_IN == rt && reads_rt));
        br = mem_branchTaken_IN;
        jump_go = id_jump_IN && (m_valid == 1);

        e.pc = m_pc; e.instr = m_instr; e.nxt = m_next; e.valid = m_valid;
        e.flush = br;
        e.stall = hazard && !br && !jump_go;
        e.fa = fwd_model(ex_rs_IN, mem_regWrite_IN, mem_rd_IN, wb_regWrite_IN, wb_rd_IN);
        e.fb = fwd_model(ex_rt_IN, mem_regWrite_IN, mem_rd_IN, wb_regWrite_IN, wb_rd_IN);
        e.sc = m_sc; e.fc = m_fc;
        q.push_back(e);
        stall_e = (e.stall == 1);

        if (e.stall == 1 && m_sc < 'hFFFF) m_sc++;
        if ((br || jump_go) && m_fc < 'hFFFF) m_fc++;
        if (br) begin
            m_pc = mem_branchTarget_IN; m_instr = 0; m_next = 0; m_valid = 0;
        end else if (jump_go) begin
            m_pc = id_jumpTarget_IN; m_instr = 0; m_next = 0; m_valid = 0;
        end else if (!hazard) begin
            m_instr = imem[m_pc / 4];
            m_pc = (m_pc + PC_STEP) % 256;
            m_next = m_pc;
            m_valid = 1;
        end
    endtask

    exp_t mon_e;

    // Monitor: compare DUT against the oldest queued expectation each cycle.
    always @(negedge clk_CPU) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            check("pc", pc_OUT, mon_e.pc);
            check("id_valid", id_valid_OUT, mon_e.valid);
            check("id_instr", id_instr_OUT, mon_e.instr);
            if (mon_e.valid == 1) check("id_nextInst", id_nextInst_OUT, mon_e.nxt);
            check("stall", stall_OUT, mon_e.stall);
            check("flush", flush_OUT, mon_e.flush);
            check("fwdA", fwdA_OUT, mon_e.fa);
            check("fwdB", fwdB_OUT, mon_e.fb);
`ifdef HAZARD_STATS_EN
            check("stallCount", stallCount_OUT, mon_e.sc);
            check("flushCount", flushCount_OUT, mon_e.fc);
`endif
        end
    end

    initial begin
        bit st;
        int guard;
        int unsigned opc [6] = '{'h00, 'h23, 'h2B, 'h04, 'h05, 'h08};
        for (int i = 0; i < 64; i++) begin
            imem[i] = {6'(opc[$urandom_range(0, 5)]), 5'($urandom_range(0, 3)),
                       5'($urandom_range(0, 3)), 16'($urandom)};
        end
        id_jump_IN = 0; id_jumpTarget_IN = 0; mem_branchTaken_IN = 0;
        mem_branchTarget_IN = 0; ex_memRead_IN = 0; ex_rs_IN = 0; ex_rt_IN = 0;
        mem_regWrite_IN = 0; wb_regWrite_IN = 0; mem_rd_IN = 0; wb_rd_IN = 0;

        #2;
        check("reset_pc", pc_OUT, RESET_PC);
        check("reset_valid", id_valid_OUT, 0);
        check("reset_instr", id_instr_OUT, 0);
        check("reset_nextInst", id_nextInst_OUT, 0);
        check("reset_stall", stall_OUT, 0);
        check("reset_flush", flush_OUT, 0);

        @(posedge clk_CPU); #1;
        rst_CPU_n = 1'b1;
        model_reset();

        for (int i = 0; i < 1500; i++) begin
            drive_and_predict(st);
            @(posedge clk_CPU); #1;
        end

        // Find a stall cycle, then assert reset between edges.
        st = 0;
        guard = 0;
        while (!st && guard < 1000) begin
            drive_and_predict(st);
            if (!st) begin
                @(posedge clk_CPU); #1;
            end
            guard++;
        end
        check("stall_found", st, 1);
        @(negedge clk_CPU); #2;
        rst_CPU_n = 1'b0;
        #1;
        check("async_rst_pc", pc_OUT, RESET_PC);
        check("async_rst_valid", id_valid_OUT, 0);
        check("async_rst_instr", id_instr_OUT, 0);
        check("async_rst_stall", stall_OUT, 0);
`ifdef HAZARD_STATS_EN
        check("async_rst_sc", stallCount_OUT, 0);
        check("async_rst_fc", flushCount_OUT, 0);
`endif
        model_reset();
        @(posedge clk_CPU); #1;
        rst_CPU_n = 1'b1;

        for (int i = 0; i < 500; i++) begin
            drive_and_predict(st);
            @(posedge clk_CPU); #1;
        end
        @(negedge clk_CPU); #1;
        check("queue_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
